croc_pad_ctrl: RTL and testbench

Parametrised pad-control layer between the SoC core and the IO pad cells.
- Routes each pad to GPIO or to one of up to three alternate peripheral functions.
- Per pad: 2-flop input synchroniser, optional input inversion, configurable debounce filter.
- Configured over a simple register port; the chip top instantiates it between the pad cells and the core.

---
 rtl/croc_pad_ctrl.sv | 133 +++++++++++++
 tb/tb_croc_pad_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/croc_pad_ctrl.sv
// Pad-control layer: per-pad function mux (GPIO / alternate / disabled), input synchroniser,
// optional inversion and debounce filter, configured through a simple word-addressed port.
module croc_pad_ctrl #(
    parameter int unsigned NumPads = 32,
    parameter int unsigned NumAlt  = 2,
    parameter int unsigned AddrW   = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      reg_req_i,
    input  logic                      reg_we_i,
    input  logic [AddrW-1:0]          reg_addr_i,
    input  logic [31:0]               reg_wdata_i,
    output logic                      reg_gnt_o,
    output logic                      reg_rvalid_o,
    output logic [31:0]               reg_rdata_o,
    output logic                      reg_err_o,
    input  logic [NumPads-1:0]        gpio_out_i,
    input  logic [NumPads-1:0]        gpio_oe_i,
    output logic [NumPads-1:0]        gpio_in_o,
    input  logic [NumAlt*NumPads-1:0] alt_out_i,
    input  logic [NumAlt*NumPads-1:0] alt_oe_i,
    output logic [NumAlt*NumPads-1:0] alt_in_o,
    output logic [NumPads-1:0]        pad_c2p_o,
    output logic [NumPads-1:0]        pad_c2p_en_o,
    input  logic [NumPads-1:0]        pad_p2c_i
);

    localparam int unsigned IdxW = (NumPads > 1) ? $clog2(NumPads) : 1;

    logic [1:0]         mode    [NumPads];
    logic [7:0]         deb_thr [NumPads];
    logic [7:0]         cnt     [NumPads];
    logic [NumPads-1:0] inv;
    logic [NumPads-1:0] deb_en;
    logic [NumPads-1:0] sync1;
    logic [NumPads-1:0] sync2;
    logic [NumPads-1:0] filt;
    logic [NumPads-1:0] x;

    logic            addr_ok;
    logic [IdxW-1:0] idx;
    logic [31:0]     rd_word;
    logic            unused_wdata;

    assign unused_wdata = ^{reg_wdata_i[31:16], reg_wdata_i[7:4]};

    assign reg_gnt_o = reg_req_i;
    assign addr_ok   = (32'(reg_addr_i) < NumPads);
    // Out-of-range addresses index pad 0 so the read mux never leaves the array.
    assign idx       = addr_ok ? reg_addr_i[IdxW-1:0] : '0;
    assign rd_word   = {15'd0, filt[idx], deb_thr[idx], 4'd0, deb_en[idx], inv[idx], mode[idx]};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inv    <= '0;
            deb_en <= '0;
            for (int p = 0; p < NumPads; p++) begin
                mode[p]    <= 2'd0;
                deb_thr[p] <= 8'd0;
            end
        end else if (reg_req_i && reg_we_i && addr_ok) begin
            mode[idx]    <= reg_wdata_i[1:0];
            inv[idx]     <= reg_wdata_i[2];
            deb_en[idx]  <= reg_wdata_i[3];
            deb_thr[idx] <= reg_wdata_i[15:8];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            reg_rvalid_o <= 1'b0;
            reg_err_o    <= 1'b0;
            reg_rdata_o  <= 32'd0;
        end else begin
            reg_rvalid_o <= reg_req_i;
            reg_err_o    <= reg_req_i && !addr_ok;
            reg_rdata_o  <= (reg_req_i && !reg_we_i && addr_ok) ? rd_word : 32'd0;
        end
    end

    assign x = sync2 ^ inv;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1 <= '0;
            sync2 <= '0;
            filt  <= '0;
            for (int p = 0; p < NumPads; p++) begin
                cnt[p] <= 8'd0;
            end
        end else begin
            sync1 <= pad_p2c_i;
            sync2 <= sync1;
            for (int p = 0; p < NumPads; p++) begin
                if (!deb_en[p]) begin
                    filt[p] <= x[p];
                    cnt[p]  <= 8'd0;
                end else if (x[p] == filt[p]) begin
                    cnt[p] <= 8'd0;
                end else if (cnt[p] >= deb_thr[p]) begin
                    // >= so a threshold lowered mid-count releases at once
                    filt[p] <= x[p];
                    cnt[p]  <= 8'd0;
                end else begin
                    cnt[p] <= cnt[p] + 8'd1;
                end
            end
        end
    end

    assign gpio_in_o = filt;

    always_comb begin
        pad_c2p_o    = '0;
        pad_c2p_en_o = '0;
        alt_in_o     = '0;
        for (int p = 0; p < NumPads; p++) begin
            if (mode[p] == 2'd0) begin
                pad_c2p_o[p]    = gpio_out_i[p];
                pad_c2p_en_o[p] = gpio_oe_i[p];
            end
            for (int a = 0; a < NumAlt; a++) begin
                if (32'(mode[p]) == 32'(a + 1)) begin
                    pad_c2p_o[p]               = alt_out_i[a*NumPads + p];
                    pad_c2p_en_o[p]            = alt_oe_i[a*NumPads + p];
                    alt_in_o[a*NumPads + p]    = filt[p];
                end
            end
        end
    end

endmodule

// File: tb/tb_croc_pad_ctrl.sv
// Self-checking bench for croc_pad_ctrl: behavioural model compared every cycle, plus
// directed scenarios with literal expectations.
module tb_croc_pad_ctrl;

    localparam int NP = 32;
    localparam int NA = 2;
    localparam int AW = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req = 1'b0;
    logic              we = 1'b0;
    logic [AW-1:0]     addr = '0;
    logic [31:0]       wdata = '0;
    logic              gnt;
    logic              rvalid;
    logic [31:0]       rdata;
    logic              err;
    logic [NP-1:0]     gpio_out = 32'hA5A5_0F07;
    logic [NP-1:0]     gpio_oe = 32'h0000_00F0;
    logic [NP-1:0]     gpio_in;
    logic [NA*NP-1:0]  alt_out = 64'h8;
    logic [NA*NP-1:0]  alt_oe = 64'h8;
    logic [NA*NP-1:0]  alt_in;
    logic [NP-1:0]     c2p;
    logic [NP-1:0]     c2p_en;
    logic [NP-1:0]     p2c = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    croc_pad_ctrl #(.NumPads(NP), .NumAlt(NA), .AddrW(AW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .reg_req_i    (req),
        .reg_we_i     (we),
        .reg_addr_i   (addr),
        .reg_wdata_i  (wdata),
        .reg_gnt_o    (gnt),
        .reg_rvalid_o (rvalid),
        .reg_rdata_o  (rdata),
        .reg_err_o    (err),
        .gpio_out_i   (gpio_out),
        .gpio_oe_i    (gpio_oe),
        .gpio_in_o    (gpio_in),
        .alt_out_i    (alt_out),
        .alt_oe_i     (alt_oe),
        .alt_in_o     (alt_in),
        .pad_c2p_o    (c2p),
        .pad_c2p_en_o (c2p_en),
        .pad_p2c_i    (p2c)
    );

    // Behavioural model state
    int   m_mode   [NP];
    int   m_thr    [NP];
    int   m_streak [NP];
    bit   m_inv    [NP];
    bit   m_deb    [NP];
    bit   m_s1     [NP];
    bit   m_s2     [NP];
    bit   m_filt   [NP];
    bit   m_rvalid;
    bit   m_err;
    int   m_rdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_word(input int p);
        return m_mode[p] + 4 * int'(m_inv[p]) + 8 * int'(m_deb[p]) + 256 * m_thr[p]
               + 65536 * int'(m_filt[p]);
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int p = 0; p < NP; p++) begin
                    m_mode[p] = 0; m_thr[p] = 0; m_streak[p] = 0; m_inv[p] = 0;
                    m_deb[p] = 0; m_s1[p] = 0; m_s2[p] = 0; m_filt[p] = 0;
                end
                m_rvalid = 0; m_err = 0; m_rdata = 0;
            end else begin
                // response sees config and filter state from before this edge
                m_rvalid = req;
                m_err    = req && (int'(addr) >= NP);
                m_rdata  = (req && !we && int'(addr) < NP) ? m_word(int'(addr)) : 0;
                for (int p = 0; p < NP; p++) begin
                    bit xv;
                    xv = m_s2[p] ^ m_inv[p];
                    if (!m_deb[p]) begin
                        m_filt[p] = xv; m_streak[p] = 0;
                    end else if (xv == m_filt[p]) begin
                        m_streak[p] = 0;
                    end else begin
                        // change must have persisted thr+1 consecutive cycles
                        m_streak[p]++;
                        if (m_streak[p] > m_thr[p]) begin
                            m_filt[p] = xv; m_streak[p] = 0;
                        end
                    end
                    m_s2[p] = m_s1[p];
                    m_s1[p] = p2c[p];
                end
                if (req && we && int'(addr) < NP) begin
                    m_mode[addr] = int'(wdata[1:0]);
                    m_inv[addr]  = wdata[2];
                    m_deb[addr]  = wdata[3];
                    m_thr[addr]  = int'(wdata[15:8]);
                end
            end
        end
    end

    initial begin
        forever begin
            logic [NP-1:0]    e_in, e_c2p, e_en;
            logic [NA*NP-1:0] e_alt;
            @(negedge clk);
            e_in = '0; e_c2p = '0; e_en = '0; e_alt = '0;
            for (int p = 0; p < NP; p++) begin
                e_in[p] = m_filt[p];
                if (m_mode[p] == 0) begin
                    e_c2p[p] = gpio_out[p];
                    e_en[p]  = gpio_oe[p];
                end else if (m_mode[p] <= NA) begin
                    e_c2p[p] = alt_out[(m_mode[p]-1)*NP + p];
                    e_en[p]  = alt_oe[(m_mode[p]-1)*NP + p];
                    e_alt[(m_mode[p]-1)*NP + p] = m_filt[p];
                end
            end
            chk("cyc_gpio_in", gpio_in, e_in);
            chk("cyc_c2p", c2p, e_c2p);
            chk("cyc_c2p_en", c2p_en, e_en);
            chk("cyc_alt_in", alt_in, e_alt);
            chk("cyc_gnt", gnt, req);
            chk("cyc_rvalid", rvalid, m_rvalid);
            if (m_rvalid) begin
                chk("cyc_rdata", rdata, 32'(m_rdata));
                chk("cyc_err", err, m_err);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_access(input logic w, input int a, input logic [31:0] d);
        req = 1'b1; we = w; addr = AW'(a); wdata = d;
        step();
        req = 1'b0; we = 1'b0; wdata = '0;
    endtask

    initial begin
        repeat (3) step();
        rst = 1'b0;
        chk("rst_rvalid", rvalid, 0);
        chk("rst_gpio_in", gpio_in, 0);
        chk("rst_c2p", c2p, 32'hA5A5_0F07);
        chk("rst_c2p_en", c2p_en, 32'h0000_00F0);

        // 3-cycle input latency, then read back live input bit
        p2c[5] = 1'b1;
        step(); step();
        chk("pad5_lat2", gpio_in[5], 0);
        step();
        chk("pad5_lat3", gpio_in[5], 1);
        reg_access(1'b0, 5, 32'h0);
        chk("rd5_rvalid", rvalid, 1);
        chk("rd5_rdata", rdata, 32'h0001_0000);
        chk("rd5_err", err, 0);

        // pad 3 to alt function 0
        reg_access(1'b1, 3, 32'h1);
        chk("wr3_rdata", rdata, 0);
        chk("alt3_c2p", c2p, 32'hA5A5_0F0F);
        chk("alt3_en", c2p_en, 32'h0000_00F8);
        p2c[3] = 1'b1;
        repeat (3) step();
        chk("alt3_in0", alt_in[3], 1);
        chk("alt3_in1", alt_in[NP+3], 0);
        chk("alt3_gpio_in", gpio_in[3], 1);

        // pad 7 debounce, thr = 4
        reg_access(1'b1, 7, 32'h0000_0408);
        p2c[7] = 1'b1;
        repeat (3) step();
        p2c[7] = 1'b0;
        repeat (6) step();
        chk("deb7_glitch", gpio_in[7], 0);
        p2c[7] = 1'b1;
        repeat (6) step();
        chk("deb7_hold6", gpio_in[7], 0);
        step();
        chk("deb7_hold7", gpio_in[7], 1);

        // pad 2 inversion, then out-of-range mode disables it
        reg_access(1'b1, 2, 32'h4);
        repeat (3) step();
        chk("inv2_gpio_in", gpio_in[2], 1);
        reg_access(1'b1, 2, 32'h7);
        chk("dis2_c2p", c2p[2], 0);
        chk("dis2_en", c2p_en[2], 0);
        chk("dis2_alt0", alt_in[2], 0);
        chk("dis2_alt1", alt_in[NP+2], 0);
        chk("dis2_gpio_in", gpio_in[2], 1);
        reg_access(1'b0, 2, 32'h0);
        chk("rd2_rdata", rdata, 32'h0001_0007);

        // out-of-range accesses
        reg_access(1'b1, NP, 32'h0000_FFFF);
        chk("oor_wr_rvalid", rvalid, 1);
        chk("oor_wr_err", err, 1);
        chk("oor_wr_rdata", rdata, 0);
        reg_access(1'b0, 255, 32'h0);
        chk("oor_rd_err", err, 1);
        chk("oor_rd_rdata", rdata, 0);
        reg_access(1'b0, 3, 32'h0);
        chk("rd3_unchanged", rdata, 32'h0001_0001);
        chk("rd3_err", err, 0);

        // back-to-back reads
        req = 1'b1; we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            addr = AW'(i);
            step();
            chk("b2b_rvalid", rvalid, 1);
        end
        req = 1'b0;
        step();
        chk("b2b_idle", rvalid, 0);

        // reset mid-debounce (count at 3) with a request pending
        p2c[7] = 1'b0;
        repeat (5) step();
        chk("mid_deb_filt", gpio_in[7], 1);
        req = 1'b1; we = 1'b0; addr = AW'(5);
        #2 rst = 1'b1;
        #1;
        chk("arst_gpio_in", gpio_in, 0);
        chk("arst_c2p", c2p, 32'hA5A5_0F07);
        chk("arst_en", c2p_en, 32'h0000_00F0);
        chk("arst_rvalid", rvalid, 0);
        step();
        req = 1'b0;
        step();
        rst = 1'b0;
        step();
        chk("post_rst_no_rsp", rvalid, 0);
        reg_access(1'b0, 7, 32'h0);
        chk("post_rst_rd7", rdata, 0);
        repeat (3) step();
        reg_access(1'b0, 3, 32'h0);
        chk("post_rst_rd3", rdata, 32'h0001_0000);
        chk("post_rst_c2p", c2p, 32'hA5A5_0F07);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
